// File: rtl/sevenseg_scan_ctrl.sv
// Scan controller for the 8-digit common-anode debug display: per-frame snapshot of the
// selected source, guard-cycle ghost blanking, brightness duty and leading-zero blanking.
module sevenseg_scan_ctrl #(
    parameter int SLOT_CYCLES = 8,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                    clk_7seg,
    input  logic                    Rst,
    input  logic                    dbg_sel,
    input  logic [31:0]             dbg_data,
    input  logic [31:0]             mmio_data,
    input  logic                    lz_en,
    input  logic [2:0]              brightness,
    input  logic                    freeze,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_done,
    output logic                    src_is_dbg
);

    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

    logic [DW-1:0]           digit, digit_n;
    logic [SW-1:0]           slot, slot_n;
    logic [4*NUM_DIGITS-1:0] snap, snap_n;
    logic [2:0]              bright_q, bright_n;
    logic                    src_n;
    logic                    slot_wrap, frame_end, load, lit, zero_above;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        unique case (n)
            4'h0: hex7 = 7'h01;  4'h1: hex7 = 7'h4F;  4'h2: hex7 = 7'h12;  4'h3: hex7 = 7'h06;
            4'h4: hex7 = 7'h4C;  4'h5: hex7 = 7'h24;  4'h6: hex7 = 7'h20;  4'h7: hex7 = 7'h0F;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h04;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h60;
            4'hC: hex7 = 7'h31;  4'hD: hex7 = 7'h42;  4'hE: hex7 = 7'h30;  default: hex7 = 7'h38;
        endcase
    endfunction

    // Outputs are registered from the next state so they line up with (digit, slot) of the same cycle.
    always_comb begin
        slot_wrap = (slot == SLOT_LAST);
        frame_end = slot_wrap && (digit == DIGIT_LAST);
        slot_n    = slot_wrap ? '0 : slot + SW'(1);
        digit_n   = frame_end ? '0 : (slot_wrap ? digit + DW'(1) : digit);
        bright_n  = (slot == '0) ? brightness : bright_q;
        load      = frame_end && !freeze;
        snap_n    = load ? (dbg_sel ? dbg_data : mmio_data) : snap;
        src_n     = load ? dbg_sel : src_is_dbg;
    end

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        blank      = '0;
        zero_above = lz_en;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (snap_n[4*i +: 4] == 4'h0);
            blank[i]   = zero_above;
        end
        nibble = snap_n[{digit_n, 2'b00} +: 4];
        lit    = !blank[digit_n] && (slot_n != '0) && (9'(slot_n) <= 9'(bright_n));
    end

    // NOTE: state uses non-blocking assignments only; reset here is synchronous and active-high.
    always_ff @(posedge clk_7seg) begin
        if (Rst) begin
            digit      <= '0;
            slot       <= '0;
            snap       <= '0;
            bright_q   <= '0;
            src_is_dbg <= 1'b0;
            an         <= '1;
            seg        <= 7'h7F;
            frame_done <= 1'b0;
        end else begin
            digit      <= digit_n;
            slot       <= slot_n;
            snap       <= snap_n;
            bright_q   <= bright_n;
            src_is_dbg <= src_n;
            an         <= lit ? ~(NUM_DIGITS'(1) << digit_n) : '1;
            seg        <= lit ? hex7(nibble) : 7'h7F;
            frame_done <= (slot_n == SLOT_LAST) && (digit_n == DIGIT_LAST);
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Self-checking bench for sevenseg_scan_ctrl: a frame-position reference model feeds a
// per-cycle scoreboard, and each scenario task adds its own directed checks.
module tb_sevenseg_scan_ctrl;

    localparam int S     = 8;
    localparam int FRAME = 8 * S;

    logic        clk_7seg = 1'b0;
    logic        Rst = 1'b1;
    logic        dbg_sel = 1'b0;
    logic [31:0] dbg_data = '0;
    logic [31:0] mmio_data = '0;
    logic        lz_en = 1'b0;
    logic [2:0]  brightness = 3'd0;
    logic        freeze = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
    logic        src_is_dbg;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       src;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          m_p = 0;
    logic [31:0] m_snap = '0;
    logic        m_src = 1'b0;
    logic [2:0]  m_bright = '0;
    logic [6:0]  seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                  7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    sevenseg_scan_ctrl #(.SLOT_CYCLES(S), .NUM_DIGITS(8)) dut (
        .clk_7seg   (clk_7seg),
        .Rst        (Rst),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .mmio_data  (mmio_data),
        .lz_en      (lz_en),
        .brightness (brightness),
        .freeze     (freeze),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done),
        .src_is_dbg (src_is_dbg)
    );

    always #5 clk_7seg = ~clk_7seg;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Advance the model on the clock edge, queue its prediction, then compare once outputs settle.
    task automatic step();
        exp_t e, got;
        int d, s;
        logic blanked, lit;
        @(posedge clk_7seg);
        if (Rst) begin
            m_p = 0; m_snap = '0; m_src = 1'b0; m_bright = '0;
        end else begin
            if (m_p % S == 0) m_bright = brightness;
            if (m_p == FRAME - 1 && !freeze) begin
                m_snap = dbg_sel ? dbg_data : mmio_data;
                m_src  = dbg_sel;
            end
            m_p = (m_p + 1) % FRAME;
        end
        d = m_p / S;
        s = m_p % S;
        blanked = lz_en && (d >= 1) && ((m_snap >> (4 * d)) == 32'h0);
        lit     = !blanked && (s >= 1) && (s <= int'(m_bright));
        e.an  = lit ? ~(8'h01 << d) : 8'hFF;
        e.seg = lit ? seg_tab[(m_snap >> (4 * d)) & 32'hF] : 7'h7F;
        e.fd  = (m_p == FRAME - 1);
        e.src = m_src;
        sb_q.push_back(e);
        #1;
        got = '{an: an, seg: seg, fd: frame_done, src: src_is_dbg};
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            if (errors <= 20)
                $display("FAIL scan p=%0d: got an=%h seg=%h fd=%b src=%b, expected an=%h seg=%h fd=%b src=%b",
                         m_p, got.an, got.seg, got.fd, got.src, e.an, e.seg, e.fd, e.src);
        end
    endtask

    task automatic goto(input int d, input int s);
        int n = 0;
        do begin
            step();
            n++;
        end while (m_p != d * S + s && n < FRAME + 2);
        checks++;
        if (m_p != d * S + s) begin
            errors++;
            $display("FAIL goto: position %0d, expected %0d", m_p, d * S + s);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        step();
        step();
        checks++;
        if ({an, seg, frame_done, src_is_dbg} !== {8'hFF, 7'h7F, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got an=%h seg=%h fd=%b src=%b, expected FF 7F 0 0",
                     an, seg, frame_done, src_is_dbg);
        end
        Rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        brightness = 3'd7; mmio_data = 32'h12345678; dbg_sel = 1'b0;
        goto(0, 1);
        checks++;
        if ({an, seg} !== {8'hFE, 7'h01}) begin
            errors++; $display("FAIL frame1_zero: got an=%h seg=%h, expected FE 01", an, seg);
        end
        goto(7, 6);
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_early: got %b expected 0", frame_done); end
        goto(7, 7);
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL fd_cycle63: got %b expected 1", frame_done); end
        goto(0, 0);
        checks++;
        if (an !== 8'hFF) begin errors++; $display("FAIL guard_slot: got an=%h expected FF", an); end
        goto(0, 1);
        checks++;
        if ({an, seg} !== {8'hFE, 7'h00}) begin
            errors++; $display("FAIL frame2_d0: got an=%h seg=%h, expected FE 00", an, seg);
        end
        goto(0, 7);
        checks++;
        if ({an, seg} !== {8'hFE, 7'h00}) begin
            errors++; $display("FAIL frame2_d0_last: got an=%h seg=%h, expected FE 00", an, seg);
        end
        goto(7, 1);
        checks++;
        if ({an, seg} !== {8'h7F, 7'h4F}) begin
            errors++; $display("FAIL frame2_d7: got an=%h seg=%h, expected 7F 4F", an, seg);
        end
    endtask

    task automatic test_lz_blank();
        mmio_data = 32'h000000A0; lz_en = 1'b1;
        goto(1, 1);
        checks++;
        if ({an, seg} !== {8'hFD, 7'h08}) begin
            errors++; $display("FAIL lz_d1: got an=%h seg=%h, expected FD 08", an, seg);
        end
        goto(2, 1);
        checks++;
        if ({an, seg} !== {8'hFF, 7'h7F}) begin
            errors++; $display("FAIL lz_d2: got an=%h seg=%h, expected FF 7F", an, seg);
        end
        goto(7, 3);
        checks++;
        if (an !== 8'hFF) begin errors++; $display("FAIL lz_d7: got an=%h expected FF", an); end
        goto(0, 1);
        checks++;
        if ({an, seg} !== {8'hFE, 7'h01}) begin
            errors++; $display("FAIL lz_d0: got an=%h seg=%h, expected FE 01", an, seg);
        end
    endtask

    task automatic test_all_zero();
        mmio_data = 32'h0;
        goto(0, 1);
        checks++;
        if ({an, seg} !== {8'hFE, 7'h01}) begin
            errors++; $display("FAIL zero_d0: got an=%h seg=%h, expected FE 01", an, seg);
        end
        goto(1, 1);
        checks++;
        if (an !== 8'hFF) begin errors++; $display("FAIL zero_d1: got an=%h expected FF", an); end
        goto(5, 4);
        checks++;
        if (an !== 8'hFF) begin errors++; $display("FAIL zero_d5: got an=%h expected FF", an); end
    endtask

    task automatic test_brightness();
        brightness = 3'd3; lz_en = 1'b0;
        goto(6, 1);
        checks++;
        if ({an, seg} !== {8'hBF, 7'h01}) begin
            errors++; $display("FAIL bright_s1: got an=%h seg=%h, expected BF 01", an, seg);
        end
        goto(6, 3);
        checks++;
        if (an !== 8'hBF) begin errors++; $display("FAIL bright_s3: got an=%h expected BF", an); end
        goto(6, 4);
        checks++;
        if (an !== 8'hFF) begin errors++; $display("FAIL bright_s4: got an=%h expected FF", an); end
        goto(7, 2);
        brightness = 3'd0;
        goto(7, 3);
        checks++;
        if (an !== 8'h7F) begin errors++; $display("FAIL bright_hold: got an=%h expected 7F", an); end
        goto(0, 1);
        checks++;
        if (an !== 8'hFF) begin errors++; $display("FAIL bright_zero: got an=%h expected FF", an); end
    endtask

    task automatic test_source_switch();
        brightness = 3'd7;
        dbg_sel = 1'b1; dbg_data = 32'hDEADBEEF;
        goto(7, 1);
        checks++;
        if ({an, seg, src_is_dbg} !== {8'h7F, 7'h01, 1'b0}) begin
            errors++; $display("FAIL src_midframe: got an=%h seg=%h src=%b, expected 7F 01 0", an, seg, src_is_dbg);
        end
        goto(7, 1);
        checks++;
        if ({an, seg, src_is_dbg} !== {8'h7F, 7'h42, 1'b1}) begin
            errors++; $display("FAIL src_dbg: got an=%h seg=%h src=%b, expected 7F 42 1", an, seg, src_is_dbg);
        end
    endtask

    task automatic test_freeze();
        dbg_sel = 1'b0; mmio_data = 32'h12345678;
        goto(0, 1);
        checks++;
        if ({seg, src_is_dbg} !== {7'h00, 1'b0}) begin
            errors++; $display("FAIL freeze_pre: got seg=%h src=%b, expected 00 0", seg, src_is_dbg);
        end
        freeze = 1'b1; dbg_sel = 1'b1; dbg_data = 32'hDEADBEEF;
        goto(7, 1);
        goto(0, 1);
        checks++;
        if ({seg, src_is_dbg} !== {7'h00, 1'b0}) begin
            errors++; $display("FAIL freeze_hold: got seg=%h src=%b, expected 00 0", seg, src_is_dbg);
        end
        goto(7, 1);
        checks++;
        if (seg !== 7'h4F) begin errors++; $display("FAIL freeze_d7: got seg=%h expected 4F", seg); end
        freeze = 1'b0; dbg_sel = 1'b0;
    endtask

    task automatic test_mid_reset();
        goto(4, 2);
        Rst = 1'b1;
        step();
        checks++;
        if ({an, seg, frame_done, src_is_dbg} !== {8'hFF, 7'h7F, 1'b0, 1'b0}) begin
            errors++; $display("FAIL midreset_outputs: got an=%h seg=%h fd=%b src=%b, expected FF 7F 0 0",
                               an, seg, frame_done, src_is_dbg);
        end
        Rst = 1'b0;
        goto(4, 1);
        checks++;
        if ({an, seg} !== {8'hEF, 7'h01}) begin
            errors++; $display("FAIL midreset_zeros: got an=%h seg=%h, expected EF 01", an, seg);
        end
        goto(0, 1);
        checks++;
        if ({an, seg} !== {8'hFE, 7'h00}) begin
            errors++; $display("FAIL midreset_reload: got an=%h seg=%h, expected FE 00", an, seg);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_lz_blank();
        test_all_zero();
        test_brightness();
        test_source_switch();
        test_freeze();
        test_mid_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
